// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared encodings, state type and defaults for the fetch stage.
package fetch_unit_pkg;
  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 32;

  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_ALWAYS = 2'b01,
    BR_IF_Z   = 2'b10,
    BR_IF_N   = 2'b11
  } br_sel_e;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1000;
  localparam logic [3:0] OP_JMP   = 4'b1001;
  localparam logic [3:0] OP_JZ    = 4'b1010;
  localparam logic [3:0] OP_JN    = 4'b1011;
  localparam logic [3:0] OP_SHL   = 4'b1100;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_REDIRECT
  } fsm_state_e;

  function automatic logic branch_taken(input logic resolve, input logic [1:0] sel,
                                        input logic z, input logic n);
    return resolve & ((sel == BR_ALWAYS) | ((sel == BR_IF_Z) & z) | ((sel == BR_IF_N) & n));
  endfunction
endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: 2-entry in-order instruction buffer; entry 0 is always the head.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] push_data_i,
  input  logic [ADDR_W-1:0]  push_addr_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [1:0]         count_o,
  output logic [INSTR_W-1:0] head_data_o,
  output logic [ADDR_W-1:0]  head_addr_o
);
  logic [1:0][INSTR_W-1:0] data_q, data_d;
  logic [1:0][ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]              count_q, count_d;
  logic                    wr_idx;

  always_comb begin
    data_d  = data_q;
    addr_d  = addr_q;
    // slot for a push once any same-cycle pop has shifted entry 1 down
    wr_idx  = count_q[1] | (count_q[0] & ~pop_i);
    if (pop_i) begin
      data_d[0] = data_q[1];
      addr_d[0] = addr_q[1];
    end
    if (push_i) begin
      data_d[wr_idx] = push_data_i;
      addr_d[wr_idx] = push_addr_i;
    end
    count_d = flush_i ? 2'd0 : count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      addr_q  <= '0;
      count_q <= 2'd0;
    end else begin
      data_q  <= data_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign head_data_o = data_q[0];
  assign head_addr_o = addr_q[0];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with 2-deep prefetch buffer and branch redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               decode_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [3:0]         opcode,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               branch_resolve,
  input  logic [1:0]         branch_select,
  input  logic               flag_z,
  input  logic               flag_n,
  input  logic [ADDR_W-1:0]  branch_target
);
  fsm_state_e        state_q;
  logic [ADDR_W-1:0] pc_q, inflight_addr_q;
  logic              inflight_q;
  logic              taken, pop, push;
  logic [1:0]        count;

  assign taken       = branch_taken(branch_resolve, branch_select, flag_z, flag_n);
  assign instr_valid = count != 2'd0;
  assign pop         = instr_valid & decode_ready;
  assign push        = inflight_q & ~taken;
  // buffered + in-flight - leaving this cycle must stay below two slots
  assign imem_req    = (state_q == ST_RUN) & ~taken &
                       (({1'b0, count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
  assign imem_addr   = pc_q;
  assign opcode      = instr_out[INSTR_W-1 -: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      inflight_q <= imem_req;
      if (imem_req) inflight_addr_q <= pc_q;
      if (taken) begin
        state_q <= ST_REDIRECT;
        pc_q    <= branch_target;
      end else begin
        state_q <= ST_RUN;
        if (imem_req) pc_q <= pc_q + ADDR_W'(4);
      end
    end
  end

  fetch_fifo #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (imem_rdata),
    .push_addr_i (inflight_addr_q),
    .pop_i       (pop),
    .flush_i     (taken),
    .count_o     (count),
    .head_data_o (instr_out),
    .head_addr_o (pc_out)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed per-cycle vector table plus an asynchronous reset pulse sequence.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n, imem_req, instr_valid, decode_ready;
  logic        branch_resolve, flag_z, flag_n;
  logic [1:0]  branch_select;
  logic [15:0] imem_addr, pc_out, branch_target;
  logic [31:0] imem_rdata, instr_out;
  logic [3:0]  opcode;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'hFFF8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .decode_ready   (decode_ready),
    .instr_out      (instr_out),
    .opcode         (opcode),
    .pc_out         (pc_out),
    .branch_resolve (branch_resolve),
    .branch_select  (branch_select),
    .flag_z         (flag_z),
    .flag_n         (flag_n),
    .branch_target  (branch_target)
  );

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {a[5:2], 12'h123, a};
  endfunction

  // memory answers one cycle after a request; idle cycles return a poison word
  always @(posedge clk) imem_rdata <= imem_req ? pat(imem_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst, dr, br;
    logic [1:0]  sel;
    logic        z, n;
    logic [15:0] tgt;
    logic        req;
    logic [15:0] addr;
    logic        val;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, dr, br, input logic [1:0] sel, input logic z, n,
                              input logic [15:0] tgt, input logic req, input logic [15:0] addr,
                              input logic val, input logic [15:0] pc);
    vec_t v;
    v.rst = rst; v.dr = dr; v.br = br; v.sel = sel; v.z = z; v.n = n; v.tgt = tgt;
    v.req = req; v.addr = addr; v.val = val; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      vec_t v;
      v = tbl[i];
      rst_n = v.rst; decode_ready = v.dr; branch_resolve = v.br;
      branch_select = v.sel; flag_z = v.z; flag_n = v.n; branch_target = v.tgt;
      @(negedge clk);
      chk($sformatf("req[%0d]", i), {31'b0, imem_req}, {31'b0, v.req});
      if (v.req) chk($sformatf("addr[%0d]", i), {16'b0, imem_addr}, {16'b0, v.addr});
      chk($sformatf("valid[%0d]", i), {31'b0, instr_valid}, {31'b0, v.val});
      if (v.val) begin
        chk($sformatf("pc[%0d]", i), {16'b0, pc_out}, {16'b0, v.pc});
        chk($sformatf("instr[%0d]", i), instr_out, pat(v.pc));
        chk($sformatf("opcode[%0d]", i), {28'b0, opcode}, {28'b0, v.pc[5:2]});
      end else if (!v.rst) begin
        chk($sformatf("rst_instr[%0d]", i), instr_out, 32'h0);
        chk($sformatf("rst_pc[%0d]", i), {16'b0, pc_out}, 32'h0);
        chk($sformatf("rst_opcode[%0d]", i), {28'b0, opcode}, 32'h0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // rows 0-29: boot with wrap, stall, branches; rows 30-35: restart after reset pulse
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'hFFF8, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'hFFFC, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'hFFF8));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'hFFFC));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0008, 1, 16'h0000));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h000C, 1, 16'h0004));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0010, 1, 16'h0008));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0014, 1, 16'h000C));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 16'h0040, 0, 16'h0000, 1, 16'h0010));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0044, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0048, 1, 16'h0040));
    tbl.push_back(mk(1, 1, 1, 2, 0, 1, 16'h0300, 1, 16'h004C, 1, 16'h0044));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 16'h0300, 1, 16'h0050, 1, 16'h0048));
    tbl.push_back(mk(1, 1, 1, 3, 1, 0, 16'h0300, 1, 16'h0054, 1, 16'h004C));
    tbl.push_back(mk(1, 0, 1, 3, 0, 1, 16'h0100, 0, 16'h0000, 1, 16'h0050));
    tbl.push_back(mk(1, 1, 1, 2, 1, 0, 16'h0200, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0200, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0204, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0208, 1, 16'h0200));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'hFFF8, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'hFFFC, 0, 16'h0000));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'hFFF8));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'hFFFC));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0008, 1, 16'h0000));

    rst_n = 1'b1; decode_ready = 1'b1; branch_resolve = 1'b0; branch_select = 2'b00;
    flag_z = 1'b0; flag_n = 1'b0; branch_target = 16'h0000;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    run(0, 29);

    // mid-cycle reset with one instruction buffered and 0x0208 in flight
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'b0, imem_req}, 32'h0);
    chk("async_valid", {31'b0, instr_valid}, 32'h0);
    chk("async_instr", instr_out, 32'h0);
    chk("async_pc", {16'b0, pc_out}, 32'h0);
    chk("async_opcode", {28'b0, opcode}, 32'h0);
    #2;
    run(30, 35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-002 The block SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 The block SHALL have parameter RESET_PC, default 16'h0000, first fetch address.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 imem_req  out  1  instruction-memory read strobe.
REQ-008 imem_addr  out  ADDR_W  read address, valid when imem_req=1.
REQ-009 imem_rdata  in  INSTR_W  read data, valid exactly one cycle after an accepted imem_req.
REQ-010 instr_valid  out  1  instr_out/pc_out/opcode hold a valid instruction.
REQ-011 decode_ready  in  1  decode stage accepts the instruction this cycle.
REQ-012 instr_out  out  INSTR_W  fetched instruction.
REQ-013 opcode  out  4  instr_out[31:28], the OpCode field feeding the control unit.
REQ-014 pc_out  out  ADDR_W  address of instr_out.
REQ-015 branch_resolve  in  1  one-cycle strobe from execute: a branch is resolved.
REQ-016 branch_select  in  2  00 none, 01 always, 10 if Z, 11 if N.
REQ-017 flag_z, flag_n  in  1 each  flags from the ALU.
REQ-018 branch_target  in  ADDR_W  redirect address, word-aligned.

Function
REQ-019 taken SHALL be branch_resolve & (sel==01 | (sel==10 & flag_z) | (sel==11 & flag_n)); branch_resolve with sel==00 or a false condition SHALL have no effect.
REQ-020 FSM states SHALL be BOOT, RUN and REDIRECT.
REQ-021 BOOT SHALL be entered on reset, SHALL hold imem_req=0 for one cycle, then go to RUN.
REQ-022 In RUN, imem_req SHALL be 1 iff taken=0 and (buffer count + in-flight − pop this cycle) < 2; imem_addr SHALL be PC; PC SHALL advance by 4 per accepted request.
REQ-023 PC SHALL wrap modulo 2^ADDR_W (16'hFFFC+4 = 16'h0000).
REQ-024 Each response SHALL be pushed into a 2-entry in-order buffer tagged with its request address.
REQ-025 Pop SHALL occur iff instr_valid & decode_ready; instr_valid SHALL equal buffer non-empty.
REQ-026 Outputs SHALL show the buffer head and SHALL stay stable while instr_valid=1 and decode_ready=0.
REQ-027 With decode_ready held 1, sustained throughput SHALL be one instruction per cycle; first instr_valid SHALL occur 3 cycles after rst_n rises (BOOT, request, response).
REQ-028 On taken, in any state, the block SHALL flush the buffer, discard the in-flight response, set PC=branch_target and enter REDIRECT.
REQ-029 REDIRECT SHALL last one cycle with imem_req=0, then go to RUN.
REQ-030 instr_valid SHALL be 0 the cycle after taken.
REQ-031 taken and pop in the same cycle: the flush SHALL win; the popped instruction counts as accepted.
REQ-032 taken during REDIRECT SHALL restart REDIRECT with the newer target.
REQ-033 If decode_ready=0 and the buffer is full, imem_req SHALL be 0 and PC SHALL hold.

Reset
REQ-034 rst_n=0 SHALL immediately set PC=RESET_PC, state=BOOT, buffer empty, in-flight=0.
REQ-035 During reset, imem_req, instr_valid, instr_out, opcode and pc_out SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL discard everything; no response arriving after rst_n rises SHALL be pushed unless requested after reset.

Structure
REQ-037 A shared package SHALL hold the branch_select encoding enum, the opcode constants (NOP=0000 … SHL=1100), the fsm state typedef and ADDR_W/INSTR_W defaults.
REQ-038 The 2-entry buffer SHALL be a sub-module fetch_fifo with push, pop, flush, count, head data/addr.

Verification
REQ-039 Reset release, decode_ready=1, imem_rdata=addr-based pattern -> requests to 0,4,8,…; instr_valid first at cycle 3; pc_out 0,4,8 on consecutive cycles.
REQ-040 decode_ready=0 for 5 cycles -> at most 2 requests outstanding/buffered, imem_req=0 after, pc_out/instr_out stable; release -> no drop, no duplicate.
REQ-041 branch_resolve=1, sel=01, target=16'h0040 -> next instr_valid=0, in-flight data discarded, next request addr 16'h0040 after one idle cycle.
REQ-042 sel=10 with flag_z=0 -> no redirect; sel=11 with flag_n=1, target=16'h0100 -> redirect to 16'h0100.
REQ-043 RESET_PC=16'hFFF8, decode_ready=1 -> request addresses FFF8, FFFC, 0000, 0004.
REQ-044 rst_n pulsed low while buffer full and a request in flight -> outputs 0 immediately; after release, fetch restarts at RESET_PC with no stale instruction.
